depth_pixel_streamer: RTL and testbench

DEPTH_PIXEL_STREAMER -- requirements
Module: depth_pixel_streamer

---
 rtl/mandel_pkg.sv | 22 ++
 rtl/depth_pixel_streamer_if.sv | 11 +
 rtl/sync_fifo.sv | 56 +++++
 rtl/depth_pixel_streamer.sv | 140 ++++++++++++++
 tb/tb_depth_pixel_streamer.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/mandel_pkg.sv
// Shared constants and types for the Mandelbrot depth-to-pixel output path:
// colour-mode encodings, pixel width and the power-on default configuration.
package mandel_pkg;

  localparam int PIX_W          = 24;
  localparam int DEF_MAX_ITER_C = 512;
  localparam int DEF_ITER_LOG_C = 9;

  typedef enum logic [1:0] {
    MODE_INVERT = 2'd0,
    MODE_GRAY   = 2'd1,
    MODE_SPLIT  = 2'd2,
    MODE_RAW    = 2'd3
  } colour_mode_e;

  typedef struct packed {
    logic [31:0]  max_iter;
    logic [4:0]   iter_log;
    colour_mode_e mode;
  } shadow_cfg_t;

endpackage

// File: rtl/depth_pixel_streamer_if.sv
// Generic valid/ready stream bundle used between the streamer and its depth FIFO.
interface depth_pixel_streamer_if #(
  parameter int W = 10
);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; push refused when full, even if
// a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  depth_pixel_streamer_if.slave  wr,
  depth_pixel_streamer_if.master rd
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             push, pop;

  assign wr.ready = (cnt_q != (AW+1)'(DEPTH));
  assign rd.valid = (cnt_q != '0);
  assign rd.data  = mem_q[rp_q];
  assign push     = wr.valid & wr.ready;
  assign pop      = rd.valid & rd.ready;

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (push) wp_d = wp_q + 1'b1;
    if (pop)  rp_d = rp_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; occupancy alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q] <= wr.data;
  end

endmodule

// File: rtl/depth_pixel_streamer.sv
// Buffers iteration depths, maps them to RGB at the FIFO read side and streams
// them out as an AXI-Stream-like raster with SOF/EOL markers and frame pulse.
module depth_pixel_streamer
  import mandel_pkg::*;
#(
  parameter int X_SIZE       = 960,
  parameter int Y_SIZE       = 720,
  parameter int DEPTH_W      = 10,
  parameter int FIFO_DEPTH   = 16,
  parameter int DEF_MAX_ITER = DEF_MAX_ITER_C,
  parameter int DEF_ITER_LOG = DEF_ITER_LOG_C
) (
  input  logic               out_stream_aclk,
  input  logic               periph_resetn,
  input  logic [DEPTH_W-1:0] in_depth,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        cfg_max_iter,
  input  logic [4:0]         cfg_iter_log,
  input  logic [1:0]         cfg_mode,
  output logic [PIX_W-1:0]   out_tdata,
  output logic               out_tvalid,
  input  logic               out_tready,
  output logic               out_tuser,
  output logic               out_tlast,
  output logic [10:0]        x_out,
  output logic [10:0]        y_out,
  output logic               frame_done
);

  localparam logic [10:0] X_LAST = 11'(X_SIZE - 1);
  localparam logic [10:0] Y_LAST = 11'(Y_SIZE - 1);
  localparam shadow_cfg_t SHD_RST = '{max_iter: 32'(DEF_MAX_ITER),
                                      iter_log: 5'(DEF_ITER_LOG),
                                      mode:     MODE_INVERT};

  function automatic logic [PIX_W-1:0] map_pixel(input logic [DEPTH_W-1:0] depth,
                                                 input shadow_cfg_t        c);
    logic [31:0] d32;
    logic [31:0] sh;
    logic [7:0]  col;
    logic        sat;
    d32 = 32'(depth);
    sat = (d32 >= c.max_iter);
    if (c.iter_log > 5'd8) sh = d32 >> (c.iter_log - 5'd8);
    else                   sh = d32 << (5'd8 - c.iter_log);
    col = sat ? 8'hFF : sh[7:0];
    map_pixel = '0;
    case (c.mode)
      MODE_INVERT: map_pixel = {~col, ~col, ~col};
      MODE_GRAY:   map_pixel = {col, col, col};
      MODE_SPLIT:  map_pixel = {col, col[3:0], col[7:4], ~col};
      MODE_RAW:    map_pixel = sat ? '0 : PIX_W'(d32);
      default:     map_pixel = '0;
    endcase
  endfunction

  depth_pixel_streamer_if #(.W(DEPTH_W)) fifo_wr ();
  depth_pixel_streamer_if #(.W(DEPTH_W)) fifo_rd ();

  logic             rdy_q, rdy_d;
  logic             vld_q, vld_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [10:0]      x_q, x_d, y_q, y_d;
  logic             fd_q, fd_d;
  shadow_cfg_t      shd_q, shd_d;
  logic             xfer, load;

  assign fifo_wr.data  = in_depth;
  assign fifo_wr.valid = in_valid & rdy_q;
  assign in_ready      = rdy_q & fifo_wr.ready;

  sync_fifo #(.WIDTH(DEPTH_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (out_stream_aclk),
    .rst_n (periph_resetn),
    .wr    (fifo_wr.slave),
    .rd    (fifo_rd.master)
  );

  // FIFO read side -> output register stage
  assign xfer          = vld_q & out_tready;
  assign fifo_rd.ready = ~vld_q | out_tready;
  assign load          = fifo_rd.valid & fifo_rd.ready;

  always_comb begin
    rdy_d = 1'b1;
    x_d   = x_q;
    y_d   = y_q;
    if (xfer) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
    // A beat loaded now lands at (x_d,y_d); frame-start beats see live config.
    shd_d = shd_q;
    if (x_d == '0 && y_d == '0)
      shd_d = '{max_iter: cfg_max_iter, iter_log: cfg_iter_log, mode: colour_mode_e'(cfg_mode)};
    vld_d = vld_q;
    pix_d = pix_q;
    if (load) begin
      vld_d = 1'b1;
      pix_d = map_pixel(fifo_rd.data, shd_d);
    end else if (xfer) begin
      vld_d = 1'b0;
    end
    fd_d = xfer && (x_q == X_LAST) && (y_q == Y_LAST);
  end

  always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
    if (!periph_resetn) begin
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
      pix_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      fd_q  <= 1'b0;
      shd_q <= SHD_RST;
    end else begin
      rdy_q <= rdy_d;
      vld_q <= vld_d;
      pix_q <= pix_d;
      x_q   <= x_d;
      y_q   <= y_d;
      fd_q  <= fd_d;
      shd_q <= shd_d;
    end
  end

  assign out_tdata  = pix_q;
  assign out_tvalid = vld_q;
  assign out_tuser  = vld_q & (x_q == '0) & (y_q == '0);
  assign out_tlast  = vld_q & (x_q == X_LAST);
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_depth_pixel_streamer.sv
// Directed bench for depth_pixel_streamer on a 4x2 raster with a 4-entry FIFO.
module tb_depth_pixel_streamer;

  logic        clk = 1'b0;
  logic        periph_resetn = 1'b0;
  logic [31:0] cfg_max_iter = 32'd512;
  logic [4:0]  cfg_iter_log = 5'd9;
  logic [1:0]  cfg_mode = 2'd0;
  logic [23:0] out_tdata;
  logic        out_tvalid, out_tready, out_tuser, out_tlast, frame_done;
  logic [10:0] x_out, y_out;

  int n_cmp = 0;
  int n_bad = 0;

  depth_pixel_streamer_if #(.W(10)) in_if ();

  depth_pixel_streamer #(
    .X_SIZE(4), .Y_SIZE(2), .DEPTH_W(10), .FIFO_DEPTH(4)
  ) dut (
    .out_stream_aclk (clk),
    .periph_resetn   (periph_resetn),
    .in_depth        (in_if.data),
    .in_valid        (in_if.valid),
    .in_ready        (in_if.ready),
    .cfg_max_iter    (cfg_max_iter),
    .cfg_iter_log    (cfg_iter_log),
    .cfg_mode        (cfg_mode),
    .out_tdata       (out_tdata),
    .out_tvalid      (out_tvalid),
    .out_tready      (out_tready),
    .out_tuser       (out_tuser),
    .out_tlast       (out_tlast),
    .x_out           (x_out),
    .y_out           (y_out),
    .frame_done      (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rdy"},   in_if.ready, 0);
    chk({tag, "_vld"},   out_tvalid, 0);
    chk({tag, "_data"},  out_tdata, 0);
    chk({tag, "_tuser"}, out_tuser, 0);
    chk({tag, "_tlast"}, out_tlast, 0);
    chk({tag, "_x"},     x_out, 0);
    chk({tag, "_y"},     y_out, 0);
    chk({tag, "_fdone"}, frame_done, 0);
  endtask

  // Asserts reset, checks idle outputs, loads new config, releases at a negedge.
  task automatic do_reset(input logic [31:0] mi, input logic [4:0] il, input logic [1:0] md);
    #2 periph_resetn = 1'b0;
    #1 chk_outputs_zero("rst");
    cfg_max_iter = mi;
    cfg_iter_log = il;
    cfg_mode     = md;
    @(negedge clk);
    periph_resetn = 1'b1;
    #1 chk("rdy_before_edge", in_if.ready, 0);
    @(posedge clk);
    #1 chk("rdy_after_edge", in_if.ready, 1);
  endtask

  task automatic push(input logic [9:0] d);
    bit ok;
    ok = 1'b0;
    in_if.data  = d;
    in_if.valid = 1'b1;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = in_if.ready;
      @(posedge clk);
      #1;
    end
    in_if.valid = 1'b0;
    if (!ok) chk("push_timeout", 0, 1);
  endtask

  // Pushes one depth into an idle block and checks the resulting beat.
  task automatic send_beat(input logic [9:0] d, input logic [23:0] ep, input int ex, input int ey);
    int n;
    push(d);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_tvalid && n < 50);
    chk("latency", n, 2);
    chk("pix",   out_tdata, ep);
    chk("x",     x_out, ex);
    chk("y",     y_out, ey);
    chk("tuser", out_tuser, (ex == 0 && ey == 0));
    chk("tlast", out_tlast, (ex == 3));
    out_tready = 1'b1;
    @(posedge clk);
    #1 out_tready = 1'b0;
    @(negedge clk);
    chk("fdone", frame_done, (ex == 3 && ey == 1));
    if (ex == 3 && ey == 1) begin
      @(negedge clk);
      chk("fdone_single", frame_done, 0);
    end
    @(posedge clk);
    #1;
  endtask

  logic [9:0]  sd [6];
  logic [23:0] dpix [5];
  int          dx [5];
  int          dy [5];

  initial begin
    int acc, got;
    bit take;
    sd   = '{10'd10, 10'd20, 10'd30, 10'd40, 10'd50, 10'd60};
    dpix = '{24'hD7D7D7, 24'hAFAFAF, 24'h878787, 24'h5F5F5F, 24'h373737};
    dx   = '{2, 3, 0, 1, 2};
    dy   = '{0, 0, 1, 1, 1};
    in_if.data  = '0;
    in_if.valid = 1'b0;
    out_tready  = 1'b0;
    repeat (2) @(posedge clk);
    do_reset(32'd512, 5'd9, 2'd0);

    // Frame 1, inverted grey; mode change mid-frame must not leak in.
    send_beat(10'd0,    24'hFFFFFF, 0, 0);
    send_beat(10'd256,  24'h7F7F7F, 1, 0);
    send_beat(10'd511,  24'h000000, 2, 0);
    cfg_mode = 2'd1;
    send_beat(10'd512,  24'h000000, 3, 0);
    send_beat(10'd100,  24'hCDCDCD, 0, 1);
    send_beat(10'd1023, 24'h000000, 1, 1);
    send_beat(10'd2,    24'hFEFEFE, 2, 1);
    send_beat(10'd300,  24'h696969, 3, 1);

    // Frame 2, plain grey from its first beat.
    send_beat(10'd256,  24'h808080, 0, 0);
    send_beat(10'd100,  24'h323232, 1, 0);
    send_beat(10'd2,    24'h010101, 2, 0);
    send_beat(10'd511,  24'hFFFFFF, 3, 0);
    send_beat(10'd512,  24'hFFFFFF, 0, 1);
    send_beat(10'd300,  24'h969696, 1, 1);

    // Leave a beat in the output stage and one in the FIFO, then reset.
    push(10'd7);
    push(10'd8);
    repeat (2) @(posedge clk);
    #1 chk("pending_vld", out_tvalid, 1);
    do_reset(32'd512, 5'd6, 2'd2);
    repeat (3) @(negedge clk);
    chk("discard_vld", out_tvalid, 0);
    @(posedge clk);
    #1;
    send_beat(10'd3, 24'h0CC0F3, 0, 0);
    send_beat(10'd6, 24'h1881E7, 1, 0);

    do_reset(32'd512, 5'd6, 2'd0);
    send_beat(10'd6, 24'hE7E7E7, 0, 0);
    send_beat(10'd3, 24'hF3F3F3, 1, 0);

    // Back-pressure: six offered, five fit (output stage + 4 FIFO entries).
    acc = 0;
    in_if.data  = sd[0];
    in_if.valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      take = in_if.ready && in_if.valid;
      @(posedge clk);
      #1;
      if (take) begin
        acc++;
        if (acc < 6) in_if.data = sd[acc];
        else         in_if.valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("stall_accepts", acc, 5);
    chk("stall_rdy",     in_if.ready, 0);
    chk("stall_vld",     out_tvalid, 1);
    chk("stall_pix",     out_tdata, 24'hD7D7D7);
    chk("stall_x",       x_out, 2);
    chk("stall_y",       y_out, 0);
    in_if.valid = 1'b0;
    out_tready  = 1'b1;
    got = 0;
    for (int c = 0; c < 30 && got < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (out_tvalid) begin
        chk("drain_pix", out_tdata, dpix[got]);
        chk("drain_x",   x_out, dx[got]);
        chk("drain_y",   y_out, dy[got]);
        got++;
      end
    end
    chk("drain_count", got, 5);
    @(posedge clk);
    #1 out_tready = 1'b0;
    @(negedge clk);
    chk("drain_empty", out_tvalid, 0);
    @(posedge clk);
    #1;

    // Raw mode with a max_iter wider than the depth field.
    do_reset(32'd1024, 5'd9, 2'd3);
    send_beat(10'd1023, 24'h0003FF, 0, 0);
    send_beat(10'd700,  24'h0002BC, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
